// File: rtl/ramp_voice_sched_if.sv
// Bus between the voice scheduler, its sample/config source, the shared ramp lookup
// and the audio output stage.
interface ramp_voice_sched_if;
  logic               sample_tick;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [15:0]        cfg_data;
  logic               phase_clr;
  logic [5:0]         ramp_idx;
  logic signed [15:0] music_i;
  logic signed [15:0] mix_o;
  logic               mix_valid;
  logic               busy;
  logic               tick_miss;

  modport master (
    output sample_tick, cfg_we, cfg_addr, cfg_data, phase_clr, music_i,
    input  ramp_idx, mix_o, mix_valid, busy, tick_miss
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_addr, cfg_data, phase_clr, music_i,
    output ramp_idx, mix_o, mix_valid, busy, tick_miss
  );
endinterface

// File: rtl/ramp_voice_sched.sv
// Four-voice phase-accumulator scheduler time-sharing one ramp lookup per sample tick;
// the four looked-up samples are summed and saturated into a 16-bit signed mix word.
module ramp_voice_sched #(
  parameter int VOICES = 4,
  parameter int ACC_W  = 16
) (
  input logic              clk,
  input logic              rst,
  ramp_voice_sched_if.slave bus
);
  localparam int                      SUM_W    = 18;
  localparam logic [5:0]              IDX_PARK = 6'd32;
  localparam logic signed [SUM_W-1:0] MIX_MAX  = 18'sd32767;
  localparam logic signed [SUM_W-1:0] MIX_MIN  = -18'sd32768;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               v_q, v_d;
  logic [1:0]               v_nxt;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [ACC_W-1:0]         acc_q [VOICES];
  logic [ACC_W-1:0]         acc_d [VOICES];
  logic [ACC_W-1:0]         inc_q [VOICES];
  logic [ACC_W-1:0]         inc_d [VOICES];
  logic [5:0]               ramp_idx_q, ramp_idx_d;
  logic signed [15:0]       mix_q, mix_d;
  logic                     mix_valid_q, mix_valid_d;
  logic                     tick_miss_q, tick_miss_d;

  function automatic logic signed [15:0] sat_mix(input logic signed [SUM_W-1:0] s);
    if (s > MIX_MAX)      return 16'sh7FFF;
    else if (s < MIX_MIN) return 16'sh8000;
    else                  return s[15:0];
  endfunction

  // Disabled voices park the lookup at its zero entry instead of reading their phase.
  function automatic logic [5:0] voice_idx(input logic [ACC_W-1:0] acc,
                                           input logic [ACC_W-1:0] inc);
    return (inc != '0) ? acc[ACC_W-1 -: 6] : IDX_PARK;
  endfunction

  assign v_nxt = v_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    sum_d       = sum_q;
    ramp_idx_d  = ramp_idx_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    tick_miss_d = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      acc_d[i] = acc_q[i];
      inc_d[i] = inc_q[i];
    end

    case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          ramp_idx_d = voice_idx(acc_q[0], inc_q[0]);
          v_d        = 2'd0;
          sum_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (inc_q[v_q] != '0) begin
          sum_d        = sum_q + $signed({{2{bus.music_i[15]}}, bus.music_i});
          acc_d[v_q]   = acc_q[v_q] + inc_q[v_q];
        end
        if (v_q != 2'd3) begin
          v_d        = v_nxt;
          ramp_idx_d = voice_idx(acc_q[v_nxt], inc_q[v_nxt]);
        end else begin
          ramp_idx_d = IDX_PARK;
          state_d    = OUT;
        end
      end
      OUT: begin
        mix_d       = sat_mix(sum_q);
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.sample_tick && (state_q != IDLE)) tick_miss_d = 1'b1;

    // Clear wins over any advance scheduled in the same cycle; the running sequence continues.
    if (bus.phase_clr) begin
      for (int i = 0; i < VOICES; i++) acc_d[i] = '0;
    end
    if (bus.cfg_we) inc_d[bus.cfg_addr] = bus.cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      v_q         <= 2'd0;
      sum_q       <= '0;
      ramp_idx_q  <= IDX_PARK;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      tick_miss_q <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      sum_q       <= sum_d;
      ramp_idx_q  <= ramp_idx_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      tick_miss_q <= tick_miss_d;
      for (int i = 0; i < VOICES; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign bus.ramp_idx  = ramp_idx_q;
  assign bus.mix_o     = mix_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.tick_miss = tick_miss_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ramp_voice_sched.sv
// Bench for ramp_voice_sched: directed literal cases plus randomized traffic checked
// every cycle against a cycle-count based reference model of the scheduler.
module tb_ramp_voice_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ramp_voice_sched_if bus_if ();

  ramp_voice_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Ramp table: -16384 at index 0 rising 512 per step, zero at 32, one LSB low above 32.
  function automatic logic signed [15:0] lut(input logic [5:0] i);
    int v;
    v = (int'(i) - 32) * 512;
    if (i > 6'd32) v = v - 1;
    return 16'(v);
  endfunction

  assign bus_if.music_i = lut(bus_if.ramp_idx);

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_acc [4];
  logic [15:0] m_inc [4];
  int          m_sum;
  bit          seq_on   = 1'b0;
  bit          model_ok = 1'b0;
  int          t0;
  int          cyc = 0;
  logic [5:0]  exp_idx;
  logic [15:0] exp_mix;
  logic        exp_valid, exp_miss, exp_busy;

  function automatic logic [5:0] pidx(input logic [15:0] a, input logic [15:0] inc);
    return (inc != 16'd0) ? a[15:10] : 6'd32;
  endfunction

  initial begin
    logic [15:0] o_acc [4];
    logic [15:0] o_inc [4];
    int k;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          m_acc[i] = 16'd0;
          m_inc[i] = 16'd0;
        end
        seq_on = 1'b0; m_sum = 0;
        exp_idx = 6'd32; exp_mix = 16'd0;
        exp_valid = 1'b0; exp_miss = 1'b0; exp_busy = 1'b0;
        model_ok = 1'b1;
      end else begin
        o_acc = m_acc;
        o_inc = m_inc;
        k = seq_on ? (cyc - t0) : 0;
        exp_valid = 1'b0;
        exp_miss  = bus_if.sample_tick && seq_on;
        if (seq_on && k <= 4) begin
          // voice k-1 is accumulated k clocks after the accepted tick
          if (o_inc[k-1] != 16'd0) begin
            m_sum += lut(exp_idx);
            m_acc[k-1] = o_acc[k-1] + o_inc[k-1];
          end
          if (k == 4) exp_idx = 6'd32;
          else        exp_idx = pidx(o_acc[k], o_inc[k]);
        end else if (seq_on) begin
          if (m_sum > 32767)       exp_mix = 16'h7FFF;
          else if (m_sum < -32768) exp_mix = 16'h8000;
          else                     exp_mix = 16'(m_sum);
          exp_valid = 1'b1;
          seq_on = 1'b0;
        end else if (bus_if.sample_tick) begin
          seq_on = 1'b1;
          t0 = cyc;
          m_sum = 0;
          exp_idx = pidx(o_acc[0], o_inc[0]);
        end
        if (bus_if.phase_clr) begin
          for (int i = 0; i < 4; i++) m_acc[i] = 16'd0;
        end
        if (bus_if.cfg_we) m_inc[bus_if.cfg_addr] = bus_if.cfg_data;
        exp_busy = seq_on;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("ramp_idx",  16'(bus_if.ramp_idx),  16'(exp_idx));
        chk("mix_o",     16'(bus_if.mix_o),     exp_mix);
        chk("mix_valid", 16'(bus_if.mix_valid), 16'(exp_valid));
        chk("busy",      16'(bus_if.busy),      16'(exp_busy));
        chk("tick_miss", 16'(bus_if.tick_miss), 16'(exp_miss));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0]  seen_idx [5];
  logic [15:0] got_mix;
  int          got_lat;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus_if.sample_tick = 1'b0; bus_if.cfg_we = 1'b0; bus_if.cfg_addr = 2'd0;
    bus_if.cfg_data = 16'd0;   bus_if.phase_clr = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d);
    bus_if.cfg_we = 1'b1; bus_if.cfg_addr = a; bus_if.cfg_data = d;
    @(negedge clk);
    bus_if.cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input logic [15:0] d);
    for (int i = 0; i < 4; i++) cfg(2'(i), d);
  endtask

  // One tick, record the index presented per voice, wait (bounded) for mix_valid.
  task automatic tick_obs();
    bus_if.sample_tick = 1'b1;
    @(negedge clk);
    bus_if.sample_tick = 1'b0;
    seen_idx[0] = bus_if.ramp_idx;
    got_lat = -1;
    got_mix = 16'hDEAD;
    for (int n = 1; n <= 12 && got_lat < 0; n++) begin
      @(negedge clk);
      if (n <= 4) seen_idx[n] = bus_if.ramp_idx;
      if (bus_if.mix_valid) begin
        got_lat = n;
        got_mix = 16'(bus_if.mix_o);
      end
    end
    idle(2);
  endtask

  initial begin
    int n_val, n_miss;
    logic [15:0] sv_exp [3];
    logic [15:0] wr_exp [3];
    sv_exp = '{16'hC000, 16'hC200, 16'hC400};
    wr_exp = '{16'hC000, 16'h3DFF, 16'h3BFF};

    // reset
    do_reset();
    chk("rst_ramp_idx",  16'(bus_if.ramp_idx),  16'd32);
    chk("rst_mix_o",     16'(bus_if.mix_o),     16'd0);
    chk("rst_busy",      16'(bus_if.busy),      16'd0);
    chk("rst_mix_valid", 16'(bus_if.mix_valid), 16'd0);
    chk("rst_tick_miss", 16'(bus_if.tick_miss), 16'd0);
    idle(3);

    // single voice stepping
    cfg(2'd0, 16'h0400);
    for (int t = 0; t < 3; t++) begin
      tick_obs();
      chk("sv_mix", got_mix, sv_exp[t]);
      chk("sv_latency", 16'(got_lat), 16'd5);
      chk("sv_idx_v0", 16'(seen_idx[0]), 16'(t));
      for (int v = 1; v <= 4; v++) chk("sv_idx_park", 16'(seen_idx[v]), 16'd32);
    end

    // wrap
    do_reset();
    cfg(2'd1, 16'hFC00);
    for (int t = 0; t < 3; t++) begin
      tick_obs();
      chk("wrap_mix", got_mix, wr_exp[t]);
    end
    chk("wrap_idx_v1", 16'(seen_idx[1]), 16'd62);

    // negative saturation
    do_reset();
    cfg_all(16'h0400);
    tick_obs();
    chk("neg_sat", got_mix, 16'h8000);

    // positive saturation
    do_reset();
    bus_if.phase_clr = 1'b1; @(negedge clk); bus_if.phase_clr = 1'b0;
    cfg_all(16'hFC00);
    tick_obs();
    chk("pos_sat_first", got_mix, 16'h8000);
    tick_obs();
    chk("pos_sat", got_mix, 16'h7FFF);

    // dropped tick while busy
    do_reset();
    cfg(2'd0, 16'h0400);
    n_val = 0; n_miss = 0;
    bus_if.sample_tick = 1'b1; @(negedge clk);
    bus_if.sample_tick = 1'b0; @(negedge clk);
    bus_if.sample_tick = 1'b1; @(negedge clk);
    bus_if.sample_tick = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (bus_if.mix_valid) n_val++;
      if (bus_if.tick_miss) n_miss++;
      @(negedge clk);
    end
    chk("busy_miss_count",  16'(n_miss), 16'd1);
    chk("busy_valid_count", 16'(n_val),  16'd1);

    // phase clear in the middle of a sequence
    cfg_all(16'h0300);
    for (int t = 0; t < 3; t++) tick_obs();
    bus_if.sample_tick = 1'b1; @(negedge clk);
    bus_if.sample_tick = 1'b0; @(negedge clk);
    bus_if.phase_clr = 1'b1;   @(negedge clk);
    bus_if.phase_clr = 1'b0;
    idle(6);
    tick_obs();
    for (int v = 0; v < 4; v++) chk("clr_idx", 16'(seen_idx[v]), 16'd0);
    chk("clr_mix", got_mix, 16'h8000);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst                = ($urandom_range(0, 399) == 0);
      bus_if.sample_tick = ($urandom_range(0, 3) == 0);
      bus_if.cfg_we      = ($urandom_range(0, 7) == 0);
      bus_if.cfg_addr    = 2'($urandom_range(0, 3));
      bus_if.cfg_data    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      bus_if.phase_clr   = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    do_reset();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ramp_voice_sched.md
# ramp_voice_sched

Four-voice scheduler for the shared 64-entry ramp wave lookup in the audio path. It keeps a phase accumulator and a programmable phase increment for each voice. On each sample tick it feeds the single lookup one voice at a time, over consecutive clocks, and sums the four returned samples. The sum is saturated to a 16-bit signed mix word and passed to the audio output stage.

## Interface
- VOICES, 4: number of voices; fixed at 4, since voice select and config address are 2 bits.
- ACC_W, 16: phase accumulator width; the lookup index is acc[ACC_W-1:ACC_W-6].
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe at the audio sample rate.
- cfg_we  in  1  write strobe for a voice's phase increment.
- cfg_addr  in  2  voice number for the write.
- cfg_data  in  16  phase increment value.
- phase_clr  in  1  synchronous clear of all four phase accumulators.
- ramp_idx  out  6  registered index driven to the shared ramp lookup.
- music_i  in  16  lookup output; combinational from ramp_idx, two's complement.
- mix_o  out  16  saturated mix word, signed; held between updates.
- mix_valid  out  1  one-cycle pulse when mix_o updates.
- busy  out  1  high when the state is not IDLE.
- tick_miss  out  1  one-cycle pulse when a sample_tick is dropped.

## Operation
- State per voice:
  - inc[v], 16 bits.
  - acc[v], 16 bits.
  - A voice is enabled when inc[v] != 0. Disabled voices add nothing to the sum and their phase does not advance.
- State machine has three states: IDLE, RUN, OUT. Registers: voice counter v (2 bits), sum (18 bits, signed).
- IDLE:
  - On sample_tick: ramp_idx <= acc[0][15:10], v <= 0, sum <= 0, next state RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If voice v is enabled: sum += sign-extended music_i, and acc[v] <= acc[v] + inc[v] (mod 2^16).
  - If v < 3: ramp_idx <= acc[v+1][15:10], v <= v+1.
  - If v == 3: ramp_idx <= 32 (lookup parked at its zero entry), next state OUT.
- OUT:
  - mix_o <= sum saturated to the range -32768..32767; mix_valid <= 1.
  - Next state IDLE.
- Saturation:
  - sum > 32767 gives 16'h7FFF.
  - sum < -32768 gives 16'h8000.
  - Otherwise mix_o is the low 16 bits of sum.
- Config writes:
  - Accepted in any state; inc[cfg_addr] <= cfg_data.
  - During RUN, an increment written in the same cycle its voice is processed does not apply to that cycle's advance; it applies from the next sample.
- phase_clr:
  - Sets every acc to 0.
  - Takes priority over a same-cycle advance.
  - A sequence already in progress is not restarted.
- Reset values:
  - acc = 0, inc = 0.
  - ramp_idx = 32, mix_o = 0.
  - mix_valid = 0, busy = 0, tick_miss = 0.
  - State IDLE, v = 0, sum = 0.
- Reset asserted mid-sequence aborts it: no mix_valid is produced.

## Timing
- Tick seen at clock edge E0: voice 0's index is presented on ramp_idx after E0.
- Voices are accumulated at edges E1..E4.
- mix_o updates at E5 and mix_valid is high for the cycle after E5. Latency is 5 clocks from the tick edge to the mix_o update.
- Minimum tick spacing is 6 clocks.
- A sample_tick seen in RUN or OUT is dropped and tick_miss pulses the next cycle.
- A sample_tick in the IDLE cycle in which mix_valid is high is accepted.
- music_i must settle within one clock of ramp_idx (combinational lookup).
- Accumulator wrap: 0xFC00 + 0x0400 = 0x0000, so the index steps from 63 back to 0.

## Test plan
- Reset: assert rst for 2 cycles, then check ramp_idx=32, mix_o=0, busy=0, no mix_valid pulses, and tick_miss=0.
- Single voice stepping: write inc[0]=0x0400, then apply 3 ticks spaced 8 clocks apart. Required: mix_o = 0xC000, then 0xC200, then 0xC400; each mix_valid exactly 5 clocks after its tick edge; ramp_idx sequence per tick is 0, 32, 32, 32, then 32 parked.
- Wrap: write inc[1]=0xFC00, then 3 ticks. Required: mix_o = 0xC000, then 0x3DFF (index 63), then 0x3BFF.
- Negative saturation: all four inc=0x0400, 1 tick, so sum = -65536. Required: mix_o=0x8000.
- Positive saturation: all four voices at acc=0xFC00 (phase_clr, then inc=0xFC00, one tick; the following tick sees index 63), so sum = 63484. Required: mix_o=0x7FFF.
- Busy and clear: tick again 2 clocks after an accepted tick. Required: tick_miss pulses once and only one mix_valid occurs. Then assert phase_clr at E2 of a sequence. Required: the next sequence reads index 0 for every voice.
